// File: rtl/shift_link_tx.sv
// shift_link_tx
//   Serial transmitter for clocked shift-register links. A parallel word is
//   accepted on a LOAD request. It is then sent bit by bit on SDO together with
//   a generated shift clock SCLK. The receiver samples on SCLK falling edges.
//   After the last bit, FS is raised for one SCLK period so that the receiving
//   register can latch its contents. DONE then pulses for one cycle.
//
// Ports:
//   C     in   system clock, all state changes on the rising edge
//   R     in   asynchronous active-low reset
//   D     in   parallel word, sampled only in the accept cycle
//   LOAD  in   send request, level-sampled while idle
//   BUSY  out  frame in progress, including the FS phase
//   DONE  out  one-cycle pulse at frame completion
//   SCLK  out  shift clock, idles high
//   SDO   out  serial data, changes only while SCLK is high
//   FS    out  frame strobe, high for one SCLK period after the last bit
module shift_link_tx #(
    parameter int DATA_W    = 8,
    parameter int DIV       = 2,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic              C,
    input  logic              R,
    input  logic [DATA_W-1:0] D,
    input  logic              LOAD,
    output logic              BUSY,
    output logic              DONE,
    output logic              SCLK,
    output logic              SDO,
    output logic              FS
);

    localparam int PH_W = $clog2(2 * DIV);
    localparam int BC_W = $clog2(DATA_W + 1);

    // The phase counts cycles within one bit period.
    // SCLK drops after the PH_FALL cycle and the bit ends after the PH_LAST cycle.
    localparam logic [PH_W-1:0] PH_FALL = PH_W'(DIV - 1);
    localparam logic [PH_W-1:0] PH_LAST = PH_W'(2 * DIV - 1);
    localparam logic [BC_W-1:0] BC_INIT = BC_W'(DATA_W);
    localparam logic [BC_W-1:0] BC_ONE  = BC_W'(1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

    state_t            state_reg, state_next;
    logic [DATA_W-1:0] shreg_reg, shreg_next;
    logic [DATA_W-1:0] shifted;
    logic [PH_W-1:0]   phase_reg, phase_next;
    logic [BC_W-1:0]   bits_reg, bits_next;
    logic              busy_reg, busy_next;
    logic              done_reg, done_next;
    logic              sclk_reg, sclk_next;
    logic              sdo_reg, sdo_next;
    logic              fs_reg, fs_next;

    // The bit to transmit next is always at the leading end of the register.
    function automatic logic head_bit(input logic [DATA_W-1:0] w);
        return MSB_FIRST ? w[DATA_W-1] : w[0];
    endfunction

    assign shifted = MSB_FIRST ? (shreg_reg << 1) : (shreg_reg >> 1);

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state_reg <= IDLE;
            shreg_reg <= '0;
            phase_reg <= '0;
            bits_reg  <= '0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
            sclk_reg  <= 1'b1;
            sdo_reg   <= 1'b0;
            fs_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            shreg_reg <= shreg_next;
            phase_reg <= phase_next;
            bits_reg  <= bits_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
            sclk_reg  <= sclk_next;
            sdo_reg   <= sdo_next;
            fs_reg    <= fs_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        shreg_next = shreg_reg;
        phase_next = phase_reg;
        bits_next  = bits_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;
        sclk_next  = sclk_reg;
        sdo_next   = sdo_reg;
        fs_next    = fs_reg;

        case (state_reg)
            IDLE: begin
                sclk_next = 1'b1;
                sdo_next  = 1'b0;
                fs_next   = 1'b0;
                busy_next = 1'b0;
                if (LOAD) begin
                    shreg_next = D;
                    bits_next  = BC_INIT;
                    phase_next = '0;
                    busy_next  = 1'b1;
                    sdo_next   = head_bit(D);
                    state_next = SHIFT;
                end
            end

            SHIFT: begin
                phase_next = phase_reg + 1'b1;
                if (phase_reg == PH_FALL) begin
                    sclk_next = 1'b0;
                end
                if (phase_reg == PH_LAST) begin
                    // At a bit boundary, SCLK rises and SDO advances on the same edge.
                    // For the final bit, SDO holds its value through LATCH.
                    phase_next = '0;
                    sclk_next  = 1'b1;
                    bits_next  = bits_reg - 1'b1;
                    if (bits_reg == BC_ONE) begin
                        state_next = LATCH;
                        fs_next    = 1'b1;
                    end else begin
                        shreg_next = shifted;
                        sdo_next   = head_bit(shifted);
                    end
                end
            end

            LATCH: begin
                phase_next = phase_reg + 1'b1;
                if (phase_reg == PH_LAST) begin
                    phase_next = '0;
                    state_next = IDLE;
                    fs_next    = 1'b0;
                    busy_next  = 1'b0;
                    sdo_next   = 1'b0;
                    done_next  = 1'b1;
                end
            end

            default: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                sclk_next  = 1'b1;
                sdo_next   = 1'b0;
                fs_next    = 1'b0;
            end
        endcase
    end

    assign BUSY = busy_reg;
    assign DONE = done_reg;
    assign SCLK = sclk_reg;
    assign SDO  = sdo_reg;
    assign FS   = fs_reg;

endmodule

// File: tb/tb_shift_link_tx.sv
module tb_shift_link_tx;

    localparam int WA = 8;
    localparam int DA = 2;
    localparam int WB = 4;
    localparam int DB = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          ra_n = 1'b0, load_a = 1'b0;
    logic [WA-1:0] d_a = '0;
    logic          busy_a, done_a, sclk_a, sdo_a, fs_a;
    logic          rb_n = 1'b0, load_b = 1'b0;
    logic [WB-1:0] d_b = '0;
    logic          busy_b, done_b, sclk_b, sdo_b, fs_b;

    shift_link_tx #(.DATA_W(WA), .DIV(DA), .MSB_FIRST(1'b1)) dut_a (
        .C(clk), .R(ra_n), .D(d_a), .LOAD(load_a),
        .BUSY(busy_a), .DONE(done_a), .SCLK(sclk_a), .SDO(sdo_a), .FS(fs_a)
    );

    shift_link_tx #(.DATA_W(WB), .DIV(DB), .MSB_FIRST(1'b0)) dut_b (
        .C(clk), .R(rb_n), .D(d_b), .LOAD(load_b),
        .BUSY(busy_b), .DONE(done_b), .SCLK(sclk_b), .SDO(sdo_b), .FS(fs_b)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard: expected serial bits in transmission order, plus one token per frame
    bit bq_a[$];
    bit bq_b[$];
    int tok_a[$];
    int tok_b[$];

    // pat holds the hand-written bit sequence, first transmitted bit leftmost
    task automatic push_frame_a(input logic [15:0] pat);
        for (int i = 0; i < WA; i++) bq_a.push_back(pat[WA-1-i]);
        tok_a.push_back(1);
    endtask

    task automatic push_frame_b(input logic [15:0] pat);
        for (int i = 0; i < WB; i++) bq_b.push_back(pat[WB-1-i]);
        tok_b.push_back(1);
    endtask

    // ---------------- monitor, instance A ----------------
    logic p_busy_a = 0, p_sclk_a = 1, p_sdo_a = 0, p_fs_a = 0, p_done_a = 0;
    int   t0_a = 0, nfall_a = 0, fs_start_a = 0, last_done_a = -100, gap_a = 0, done_cnt_a = 0;

    always @(negedge clk) begin
        if (!ra_n) begin
            chk("a_reset_outputs", {busy_a, done_a, sclk_a, sdo_a, fs_a}, 5'b00100);
            bq_a.delete();
            tok_a.delete();
            p_busy_a = 0; p_sclk_a = 1; p_sdo_a = 0; p_fs_a = 0; p_done_a = 0;
        end else begin
            if (busy_a && !p_busy_a) begin
                t0_a    = cyc;
                nfall_a = 0;
                gap_a   = cyc - last_done_a;
                chk("a_frame_expected", (tok_a.size() > 0) ? 1 : 0, 1);
                if (tok_a.size() > 0) void'(tok_a.pop_front());
            end
            if (!busy_a)
                chk("a_idle_lines", {sclk_a, sdo_a, fs_a}, 3'b100);
            if (p_sclk_a && !sclk_a) begin
                chk("a_fall_time", cyc - t0_a, DA + 2 * DA * nfall_a);
                chk("a_bit_available", (bq_a.size() > 0) ? 1 : 0, 1);
                if (bq_a.size() > 0) chk("a_sdo_bit", sdo_a, bq_a.pop_front());
                nfall_a++;
            end
            if (!p_sclk_a && !sclk_a)
                chk("a_sdo_stable_low", sdo_a, p_sdo_a);
            if (fs_a && !p_fs_a) begin
                chk("a_fs_start", cyc - t0_a, 2 * DA * WA);
                chk("a_fs_bits_sent", nfall_a, WA);
                fs_start_a = cyc;
            end
            if (fs_a)
                chk("a_fs_sclk_high", sclk_a, 1);
            if (!fs_a && p_fs_a)
                chk("a_fs_len", cyc - fs_start_a, 2 * DA);
            if (done_a) begin
                chk("a_done_time", cyc - t0_a, 2 * DA * (WA + 1));
                chk("a_done_one_cycle", p_done_a, 0);
                chk("a_done_in_frame", p_busy_a, 1);
                done_cnt_a++;
                last_done_a = cyc;
            end
            if (!busy_a && p_busy_a)
                chk("a_busy_len", cyc - t0_a, 2 * DA * (WA + 1));
            p_busy_a = busy_a; p_sclk_a = sclk_a; p_sdo_a = sdo_a; p_fs_a = fs_a; p_done_a = done_a;
        end
    end

    // ---------------- monitor, instance B ----------------
    logic p_busy_b = 0, p_sclk_b = 1, p_sdo_b = 0;
    int   t0_b = 0, nfall_b = 0, done_cnt_b = 0;

    always @(negedge clk) begin
        if (!rb_n) begin
            chk("b_reset_outputs", {busy_b, done_b, sclk_b, sdo_b, fs_b}, 5'b00100);
            bq_b.delete();
            tok_b.delete();
            p_busy_b = 0; p_sclk_b = 1; p_sdo_b = 0;
        end else begin
            if (busy_b && !p_busy_b) begin
                t0_b    = cyc;
                nfall_b = 0;
                chk("b_frame_expected", (tok_b.size() > 0) ? 1 : 0, 1);
                if (tok_b.size() > 0) void'(tok_b.pop_front());
            end
            if (p_sclk_b && !sclk_b) begin
                chk("b_fall_time", cyc - t0_b, DB + 2 * DB * nfall_b);
                chk("b_bit_available", (bq_b.size() > 0) ? 1 : 0, 1);
                if (bq_b.size() > 0) chk("b_sdo_bit", sdo_b, bq_b.pop_front());
                nfall_b++;
            end
            if (!p_sclk_b && !sclk_b)
                chk("b_sdo_stable_low", sdo_b, p_sdo_b);
            if (done_b) begin
                chk("b_done_time", cyc - t0_b, 2 * DB * (WB + 1));
                chk("b_done_bits_sent", nfall_b, WB);
                done_cnt_b++;
            end
            if (!busy_b && p_busy_b)
                chk("b_busy_len", cyc - t0_b, 2 * DB * (WB + 1));
            p_busy_b = busy_b; p_sclk_b = sclk_b; p_sdo_b = sdo_b;
        end
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done_a(input int target);
        int n = 0;
        while (done_cnt_a < target && n < 200) begin
            step();
            n++;
        end
        chk("a_done_count", done_cnt_a, target);
    endtask

    task automatic wait_done_b(input int target);
        int n = 0;
        while (done_cnt_b < target && n < 200) begin
            step();
            n++;
        end
        chk("b_done_count", done_cnt_b, target);
    endtask

    // Start an A5 frame, then pull reset low between the edges that follow t0+edge_n
    task automatic reset_mid(input int edge_n, input logic [4:0] exp_before);
        int base;
        base = done_cnt_a;
        push_frame_a(16'b10100101);
        d_a    = 8'hA5;
        load_a = 1'b1;
        @(posedge clk);
        #1 load_a = 1'b0;
        chk("mid_pre_busy", busy_a, 1);
        repeat (edge_n - 1) @(posedge clk);
        #2 chk("mid_pre_lines", {busy_a, done_a, sclk_a, sdo_a, fs_a}, exp_before);
        @(posedge clk);
        #3 ra_n = 1'b0;
        #1 chk("mid_async_reset", {busy_a, done_a, sclk_a, sdo_a, fs_a}, 5'b00100);
        step();
        step();
        ra_n = 1'b1;
        repeat (6) step();
        chk("mid_no_done", done_cnt_a, base);
        chk("mid_idle_busy", busy_a, 0);
    endtask

    initial begin
        // Reset held while LOAD toggles; the monitors check every cycle
        for (int i = 0; i < 3; i++) begin
            step();
            load_a = ~load_a;
            load_b = ~load_b;
            d_a    = 8'hFF;
            d_b    = 4'hF;
        end
        step();
        load_a = 1'b0;
        load_b = 1'b0;
        ra_n   = 1'b1;
        rb_n   = 1'b1;
        step();
        chk("post_reset_busy_a", busy_a, 0);
        chk("post_reset_busy_b", busy_b, 0);

        // Default frame 0xA5, MSB first
        d_a    = 8'hA5;
        load_a = 1'b1;
        push_frame_a(16'b10100101);
        step();
        load_a = 1'b0;
        wait_done_a(1);
        $display("frame a: D=0xA5 done_count=%0d", done_cnt_a);
        repeat (3) step();

        // LSB first, DIV=1, D=0x3
        d_b    = 4'h3;
        load_b = 1'b1;
        push_frame_b(16'b1100);
        step();
        load_b = 1'b0;
        wait_done_b(1);
        $display("frame b: D=0x3 done_count=%0d", done_cnt_b);
        repeat (3) step();

        // A LOAD while busy is ignored, and a D change then has no effect
        d_a    = 8'hF0;
        load_a = 1'b1;
        push_frame_a(16'b11110000);
        step();
        load_a = 1'b0;
        repeat (4) step();
        d_a    = 8'h0F;
        load_a = 1'b1;
        step();
        load_a = 1'b0;
        wait_done_a(2);
        repeat (12) step();
        chk("ignored_single_done", done_cnt_a, 2);
        chk("ignored_idle", busy_a, 0);
        $display("frame a: D=0xF0 with ignored load, done_count=%0d", done_cnt_a);

        // Back-to-back frames with LOAD held high
        d_a    = 8'h81;
        load_a = 1'b1;
        push_frame_a(16'b10000001);
        push_frame_a(16'b10000001);
        wait_done_a(3);
        chk("b2b_done_cycle_idle", busy_a, 0);
        step();
        chk("b2b_restart_busy", busy_a, 1);
        chk("b2b_gap", gap_a, 1);
        load_a = 1'b0;
        wait_done_a(4);
        $display("frames a: D=0x81 back-to-back, gap=%0d", gap_a);
        repeat (3) step();

        // Reset mid-frame at t0+13 (SCLK high, bit 3 = 0)
        reset_mid(13, 5'b10100);
        // Reset mid-frame at t0+11 (SCLK low, bit 2 = 1)
        reset_mid(11, 5'b10010);
        $display("reset mid-frame: done_count=%0d", done_cnt_a);

        // A fresh frame after the reset
        d_a    = 8'h3C;
        load_a = 1'b1;
        push_frame_a(16'b00111100);
        step();
        load_a = 1'b0;
        wait_done_a(5);
        $display("frame a: D=0x3C after reset, done_count=%0d", done_cnt_a);
        repeat (3) step();

        chk("a_queue_drained", bq_a.size(), 0);
        chk("b_queue_drained", bq_b.size(), 0);
        chk("a_tokens_drained", tok_a.size(), 0);
        chk("b_tokens_drained", tok_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
